test_mem_host: RTL and testbench
================================

TEST_MEM_HOST -- requirements
Module: test_mem_host

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 65536, memory depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter IMEM_LAT, default 1, instruction response latency in cycles (>=1).
REQ-003 SHALL have parameter DMEM_LAT, default 1, data response latency in cycles (>=1).
REQ-004 SHALL have parameter SIG_DEPTH, default 16, signature FIFO depth (power of 2, >=2).
REQ-005 SHALL have parameters SIG_ADDR 32'hF0000004, HALT_ADDR 32'hF0000000, HALT_MAGIC 32'hCAFECAFE, INIT_FILE "" (hex image).
REQ-006 SHALL have port sysclk input 1 system clock; one clock domain.
REQ-007 SHALL have port nrst_in input 1 reset, asynchronous, active-low.
REQ-008 SHALL have ports imem_req input 1, imem_addr input 32, imem_ready output 1, imem_data output 32: instruction read port.
REQ-009 SHALL have ports dmem_req input 1, dmem_we input 1, dmem_addr input 32, dmem_wstrb input 4, dmem_wdata input 32, dmem_ready output 1, dmem_rdata output 32: data port.
REQ-010 SHALL have ports sig_valid output 1, sig_data output 32, sig_ready input 1: signature stream.
REQ-011 SHALL have ports halted output 1 (sticky halt flag), cycle_count output 32 (cycles since reset).

Function
REQ-012 Each port SHALL run its own FSM: IDLE -> WAIT (counter loaded LAT-1; skipped when LAT=1) -> RESP -> IDLE.
REQ-013 Request SHALL be accepted at edge k when FSM is IDLE and req=1; ready SHALL be registered, high for exactly one cycle, asserted at edge k+LAT-1 (RESP); requester holds addr/we/wstrb/wdata stable until ready.
REQ-014 Throughput SHALL be one transaction per LAT+1 cycles per port; req high in RESP is accepted only after returning to IDLE.
REQ-015 Memory word index SHALL be addr[log2(MEM_WORDS)+1:2]; higher bits alias; addr[1:0] ignored.
REQ-016 Read data SHALL be captured on entry to RESP and held until next RESP; it reflects memory before any write committing on the same edge (read-before-write, both ports).
REQ-017 Writes SHALL commit on the RESP-entry edge, per-byte per dmem_wstrb; wstrb=0 writes nothing but still completes.
REQ-018 Write with dmem_addr==SIG_ADDR (full 32-bit compare) SHALL not touch memory and SHALL push dmem_wdata into the signature FIFO.
REQ-019 If the FIFO is full and no pop occurs that edge, a SIG_ADDR write SHALL stall in WAIT (no ready) until space; full with simultaneous pop SHALL accept the push.
REQ-020 sig_valid SHALL equal FIFO non-empty; sig_data SHALL be the head entry; pop on sig_valid & sig_ready; order preserved.
REQ-021 Write to HALT_ADDR with wdata==HALT_MAGIC SHALL set halted on the commit edge; other HALT_ADDR writes SHALL be ignored; neither touches memory.
REQ-022 Once halted, dmem writes SHALL still complete (ready) with no effect; reads and FIFO draining SHALL continue.
REQ-023 Reads of SIG_ADDR SHALL return FIFO occupancy zero-extended; reads of HALT_ADDR SHALL return {31'b0, halted}.
REQ-024 cycle_count SHALL increment each edge after reset release, stop while halted, saturate at 32'hFFFFFFFF.
REQ-025 Memory SHALL be loaded from INIT_FILE at time zero when non-empty, else zero.

Reset
REQ-026 nrst_in low SHALL immediately force: FSMs IDLE, imem_ready/dmem_ready 0, imem_data/dmem_rdata 0, FIFO empty, sig_valid 0, halted 0, cycle_count 0.
REQ-027 Reset mid-transaction SHALL abandon it with no memory write or FIFO push; memory contents SHALL be preserved.

Verification
REQ-028 IMEM_LAT=3, word 0x10 preloaded 0x00500093, imem_req at edge k -> imem_ready only at edge k+2, imem_data 0x00500093.
REQ-029 Word 0x200 = 0x11223344, write 0xAABBCCDD wstrb 4'b0101 -> read returns 0x11BB33DD.
REQ-030 SIG_DEPTH=4, sig_ready=0, five SIG_ADDR writes 1..5 -> fifth stalls; one pop -> fifth completes; drain yields 1,2,3,4,5.
REQ-031 Write 0x12345678 to HALT_ADDR -> halted stays 0; write 0xCAFECAFE -> halted 1, cycle_count frozen, later write to 0x100 leaves memory unchanged.
REQ-032 Simultaneous dmem write 0xDEADBEEF and imem read of same word, both RESP same edge -> imem_data old value; next fetch 0xDEADBEEF.
REQ-033 nrst_in low during DMEM_LAT=4 write WAIT -> target word unchanged, all outputs at reset values.

Source files
------------

// File: rtl/test_mem_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : test_mem_host                                                |
// | Description : Simulation/test memory host for a CPU core. One shared word  |
// |               memory serves an instruction read port and a data port, each |
// |               with its own fixed-latency handshake FSM. Data writes to     |
// |               SIG_ADDR feed a signature FIFO, a magic write to HALT_ADDR   |
// |               sets a sticky halt flag, and a saturating cycle counter runs |
// |               until halt.                                                  |
// | Ports       : sysclk / nrst_in        - clock, async active-low reset      |
// |               imem_req/addr/ready/data - instruction read port             |
// |               dmem_req/we/addr/wstrb/wdata/ready/rdata - data port         |
// |               sig_valid/sig_data/sig_ready - signature stream out          |
// |               halted, cycle_count      - status                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module test_mem_host #(
    parameter int          MEM_WORDS  = 65536,
    parameter int          IMEM_LAT   = 1,
    parameter int          DMEM_LAT   = 1,
    parameter int          SIG_DEPTH  = 16,
    parameter logic [31:0] SIG_ADDR   = 32'hF0000004,
    parameter logic [31:0] HALT_ADDR  = 32'hF0000000,
    parameter logic [31:0] HALT_MAGIC = 32'hCAFECAFE,
    parameter              INIT_FILE  = ""
) (
    input  logic        sysclk,
    input  logic        nrst_in,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    output logic [31:0] imem_data,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata,
    output logic        sig_valid,
    output logic [31:0] sig_data,
    input  logic        sig_ready,
    output logic        halted,
    output logic [31:0] cycle_count
);

    localparam int AW  = $clog2(MEM_WORDS);
    localparam int FW  = $clog2(SIG_DEPTH);
    localparam int ICW = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;
    localparam int DCW = (DMEM_LAT > 1) ? $clog2(DMEM_LAT) : 1;

    localparam logic [FW:0] FIFO_FULL_CNT = (FW + 1)'(SIG_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Storage (not reset: contents survive nrst_in)
    logic [31:0] mem      [0:MEM_WORDS-1];
    logic [31:0] fifo_mem [0:SIG_DEPTH-1];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    end

    // Registered state
    logic [1:0]     i_state_q, i_state_d;
    logic [ICW-1:0] i_cnt_q,   i_cnt_d;
    logic           i_ready_q, i_ready_d;
    logic [31:0]    i_data_q,  i_data_d;

    logic [1:0]     d_state_q, d_state_d;
    logic [DCW-1:0] d_cnt_q,   d_cnt_d;
    logic           d_ready_q, d_ready_d;
    logic [31:0]    d_rdata_q, d_rdata_d;

    logic [FW-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [FW-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [FW:0]    fifo_cnt_q, fifo_cnt_d;

    logic           halted_q, halted_d;
    logic [31:0]    cycle_q,  cycle_d;

    // Address decode and memory read taps
    logic [AW-1:0]  w_i_idx, w_d_idx;
    logic [31:0]    w_i_word, w_d_word, w_occ;
    logic           w_d_is_sig, w_d_is_halt;
    logic           w_full, w_pop, w_sig_block;
    logic           w_i_enter, w_d_due, w_d_commit;
    logic           w_wr_eff, w_push, w_halt_set, w_mem_we;

    assign w_i_idx     = imem_addr[AW+1:2];
    assign w_d_idx     = dmem_addr[AW+1:2];
    assign w_i_word    = mem[w_i_idx];
    assign w_d_word    = mem[w_d_idx];
    assign w_occ       = 32'(fifo_cnt_q);
    assign w_d_is_sig  = (dmem_addr == SIG_ADDR);
    assign w_d_is_halt = (dmem_addr == HALT_ADDR);

    assign w_full      = (fifo_cnt_q == FIFO_FULL_CNT);
    assign w_pop       = (fifo_cnt_q != '0) && sig_ready;
    // A signature push with no room this edge holds the data port in WAIT.
    // Once halted, the write has no effect and so never needs room.
    assign w_sig_block = dmem_we && w_d_is_sig && !halted_q && w_full && !w_pop;

    // Status registers are visible at their addresses; everything else is memory.
    function automatic logic [31:0] f_read(input logic [31:0] addr,
                                           input logic [31:0] word,
                                           input logic [31:0] occ,
                                           input logic        hlt);
        if (addr == SIG_ADDR)       f_read = occ;
        else if (addr == HALT_ADDR) f_read = {31'b0, hlt};
        else                        f_read = word;
    endfunction

    // Instruction port FSM
    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        i_ready_d = 1'b0;
        i_data_d  = i_data_q;
        w_i_enter = 1'b0;
        case (i_state_q)
            ST_IDLE: begin
                if (imem_req) begin
                    if (IMEM_LAT == 1) begin
                        w_i_enter = 1'b1;
                    end else begin
                        i_state_d = ST_WAIT;
                        i_cnt_d   = ICW'(IMEM_LAT - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (i_cnt_q == ICW'(1)) w_i_enter = 1'b1;
                else                    i_cnt_d   = i_cnt_q - ICW'(1);
            end
            ST_RESP: i_state_d = ST_IDLE;
            default: i_state_d = ST_IDLE;
        endcase
        if (w_i_enter) begin
            i_state_d = ST_RESP;
            i_ready_d = 1'b1;
            i_data_d  = f_read(imem_addr, w_i_word, w_occ, halted_q);
        end
    end

    // Data port FSM
    always_comb begin
        d_state_d  = d_state_q;
        d_cnt_d    = d_cnt_q;
        d_ready_d  = 1'b0;
        d_rdata_d  = d_rdata_q;
        w_d_due    = 1'b0;
        w_d_commit = 1'b0;
        case (d_state_q)
            ST_IDLE: begin
                if (dmem_req) begin
                    if (DMEM_LAT == 1) begin
                        w_d_due = 1'b1;
                    end else begin
                        d_state_d = ST_WAIT;
                        d_cnt_d   = DCW'(DMEM_LAT - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (d_cnt_q == DCW'(1)) w_d_due = 1'b1;
                else                    d_cnt_d = d_cnt_q - DCW'(1);
            end
            ST_RESP: d_state_d = ST_IDLE;
            default: d_state_d = ST_IDLE;
        endcase
        if (w_d_due) begin
            if (w_sig_block) begin
                // Park in WAIT with the counter at its final value so the
                // push is retried every edge until the FIFO has space.
                d_state_d = ST_WAIT;
                d_cnt_d   = DCW'(1);
            end else begin
                d_state_d  = ST_RESP;
                d_ready_d  = 1'b1;
                d_rdata_d  = f_read(dmem_addr, w_d_word, w_occ, halted_q);
                w_d_commit = 1'b1;
            end
        end
    end

    // Write side effects, all on the RESP-entry edge
    assign w_wr_eff   = w_d_commit && dmem_we && !halted_q;
    assign w_push     = w_wr_eff && w_d_is_sig;
    assign w_halt_set = w_wr_eff && w_d_is_halt && (dmem_wdata == HALT_MAGIC);
    // nrst_in gate: with DMEM_LAT=1 the commit path is combinational from IDLE.
    assign w_mem_we   = w_wr_eff && !w_d_is_sig && !w_d_is_halt && nrst_in;

    // Signature FIFO bookkeeping and status
    always_comb begin
        wr_ptr_d   = w_push ? wr_ptr_q + FW'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + FW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({w_push, w_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (FW + 1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (FW + 1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        halted_d = halted_q || w_halt_set;
        cycle_d  = (halted_q || (cycle_q == 32'hFFFFFFFF)) ? cycle_q : cycle_q + 32'd1;
    end

    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            i_state_q  <= ST_IDLE;
            i_cnt_q    <= '0;
            i_ready_q  <= 1'b0;
            i_data_q   <= 32'h0;
            d_state_q  <= ST_IDLE;
            d_cnt_q    <= '0;
            d_ready_q  <= 1'b0;
            d_rdata_q  <= 32'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            halted_q   <= 1'b0;
            cycle_q    <= 32'h0;
        end else begin
            i_state_q  <= i_state_d;
            i_cnt_q    <= i_cnt_d;
            i_ready_q  <= i_ready_d;
            i_data_q   <= i_data_d;
            d_state_q  <= d_state_d;
            d_cnt_q    <= d_cnt_d;
            d_ready_q  <= d_ready_d;
            d_rdata_q  <= d_rdata_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            halted_q   <= halted_d;
            cycle_q    <= cycle_d;
        end
    end

    // Memory byte writes; reads above sample the pre-edge contents.
    always_ff @(posedge sysclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wstrb[b]) mem[w_d_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (w_push) fifo_mem[wr_ptr_q] <= dmem_wdata;
    end

    assign imem_ready  = i_ready_q;
    assign imem_data   = i_data_q;
    assign dmem_ready  = d_ready_q;
    assign dmem_rdata  = d_rdata_q;
    assign sig_valid   = (fifo_cnt_q != '0);
    assign sig_data    = fifo_mem[rd_ptr_q];
    assign halted      = halted_q;
    assign cycle_count = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_test_mem_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_test_mem_host                                             |
// | Description : Directed self-checking bench for test_mem_host with a        |
// |               reference memory model and expected-value queues.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_test_mem_host;

    localparam logic [31:0] C_SIG   = 32'hF0000004;
    localparam logic [31:0] C_HALT  = 32'hF0000000;
    localparam logic [31:0] C_MAGIC = 32'hCAFECAFE;

    logic        sysclk = 1'b0;
    logic        nrst_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        sig_valid;
    logic [31:0] sig_data;
    logic        sig_ready;
    logic        halted;
    logic [31:0] cycle_count;

    always #5 sysclk = ~sysclk;

    test_mem_host #(
        .MEM_WORDS (1024),
        .IMEM_LAT  (3),
        .DMEM_LAT  (4),
        .SIG_DEPTH (4)
    ) u_dut (
        .sysclk      (sysclk),
        .nrst_in     (nrst_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .sig_valid   (sig_valid),
        .sig_data    (sig_data),
        .sig_ready   (sig_ready),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl [0:1023];
    logic        mdl_halted = 1'b0;
    logic [31:0] q_rd  [$];
    logic [31:0] q_imem[$];
    logic [31:0] q_sig [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == C_SIG)       return 32'(q_sig.size());
        else if (a == C_HALT) return {31'b0, mdl_halted};
        else                  return mdl[a[11:2]];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        if (mdl_halted) return;
        if (a == C_SIG) q_sig.push_back(d);
        else if (a == C_HALT) begin
            if (d == C_MAGIC) mdl_halted = 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[a[11:2]][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // exp_lat < 0: latency not fixed (stall case), only completion is checked.
    task automatic dmem_op(input string tag, input logic we, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d, input int exp_lat);
        int n;
        if (!we) q_rd.push_back(model_read(a));
        dmem_req = 1'b1; dmem_we = we; dmem_addr = a; dmem_wstrb = s; dmem_wdata = d;
        n = 0;
        do begin step(); n++; end while (!dmem_ready && n < 60);
        dmem_req = 1'b0;
        if (exp_lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        else              chk({tag, "_done"}, {31'b0, dmem_ready}, 32'd1);
        if (dmem_ready) begin
            if (!we) chk({tag, "_rdata"}, dmem_rdata, q_rd.pop_front());
            else     model_write(a, s, d);
        end else if (!we) begin
            void'(q_rd.pop_front());
        end
        step();
        chk({tag, "_ready_pulse"}, {31'b0, dmem_ready}, 32'd0);
    endtask

    task automatic imem_op(input string tag, input logic [31:0] a);
        int n;
        q_imem.push_back(model_read(a));
        imem_req = 1'b1; imem_addr = a;
        n = 0;
        do begin step(); n++; end while (!imem_ready && n < 60);
        imem_req = 1'b0;
        chk({tag, "_lat"}, 32'(n), 32'd3);
        chk({tag, "_data"}, imem_data, q_imem.pop_front());
    endtask

    initial begin
        logic [31:0] c_frozen;
        int          seen;
        int          guard;
        for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
        nrst_in = 1'b0; imem_req = 1'b0; imem_addr = '0; dmem_req = 1'b0; dmem_we = 1'b0;
        dmem_addr = '0; dmem_wstrb = '0; dmem_wdata = '0; sig_ready = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        chk("rst_imem_ready", {31'b0, imem_ready}, 32'd0);
        chk("rst_dmem_ready", {31'b0, dmem_ready}, 32'd0);
        chk("rst_sig_valid",  {31'b0, sig_valid},  32'd0);
        chk("rst_halted",     {31'b0, halted},     32'd0);
        chk("rst_cycles",     cycle_count,         32'd0);
        nrst_in = 1'b1;
        repeat (5) step();
        chk("cycle_count_5", cycle_count, 32'd5);

        // Byte-strobe merge
        dmem_op("w200_full",  1'b1, 32'h0000_0800, 4'hF, 32'h11223344, 4);
        dmem_op("w200_strb",  1'b1, 32'h0000_0800, 4'b0101, 32'hAABBCCDD, 4);
        dmem_op("r200",       1'b0, 32'h0000_0800, 4'h0, 32'h0, 4);
        chk("r200_value", dmem_rdata, 32'h11BB33DD);

        // Instruction fetch latency, strobe-zero write, aliasing
        dmem_op("w010",       1'b1, 32'h0000_0040, 4'hF, 32'h00500093, 4);
        imem_op("f010",       32'h0000_0040);
        chk("f010_value", imem_data, 32'h00500093);
        dmem_op("w010_strb0", 1'b1, 32'h0000_0040, 4'h0, 32'hFFFFFFFF, 4);
        dmem_op("r010",       1'b0, 32'h0000_0040, 4'h0, 32'h0, 4);
        imem_op("f010_alias", 32'h0001_0043);

        // Same-edge write and fetch of one word: fetch sees the old value
        dmem_op("w080",       1'b1, 32'h0000_0200, 4'hF, 32'h00001111, 4);
        fork
            dmem_op("w080_new", 1'b1, 32'h0000_0200, 4'hF, 32'hDEADBEEF, 4);
            begin
                step();
                imem_op("f080_old", 32'h0000_0200);
            end
        join
        imem_op("f080_new",   32'h0000_0200);
        chk("f080_new_value", imem_data, 32'hDEADBEEF);

        // Signature FIFO: fill, stall, pop-with-push, drain in order
        for (int v = 1; v <= 4; v++)
            dmem_op("sig_push", 1'b1, C_SIG, 4'hF, 32'(v), 4);
        chk("sig_valid_full", {31'b0, sig_valid}, 32'd1);
        dmem_op("sig_occ",    1'b0, C_SIG, 4'h0, 32'h0, 4);
        fork
            dmem_op("sig_push5", 1'b1, C_SIG, 4'hF, 32'd5, -1);
            begin
                seen = 0;
                for (int i = 0; i < 10; i++) begin
                    step();
                    if (dmem_ready) seen++;
                end
                chk("sig_stall", 32'(seen), 32'd0);
                chk("sig_head", sig_data, q_sig.pop_front());
                sig_ready = 1'b1;
                step();
                sig_ready = 1'b0;
            end
        join
        sig_ready = 1'b1;
        guard = 0;
        while (q_sig.size() > 0 && guard < 20) begin
            chk("sig_drain_valid", {31'b0, sig_valid}, 32'd1);
            chk("sig_drain_data", sig_data, q_sig.pop_front());
            step();
            guard++;
        end
        sig_ready = 1'b0;
        chk("sig_empty", {31'b0, sig_valid}, 32'd0);

        // Reset in the middle of a write wait
        dmem_op("w300",       1'b1, 32'h0000_0C00, 4'hF, 32'h01020304, 4);
        dmem_op("sig_pre",    1'b1, C_SIG, 4'hF, 32'h77, 4);
        chk("sig_pre_valid", {31'b0, sig_valid}, 32'd1);
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h0000_0C00;
        dmem_wstrb = 4'hF; dmem_wdata = 32'h55AA55AA;
        step();
        step();
        #1 nrst_in = 1'b0;
        #1;
        chk("mid_rst_dmem_ready", {31'b0, dmem_ready}, 32'd0);
        chk("mid_rst_rdata",      dmem_rdata,          32'd0);
        chk("mid_rst_imem_data",  imem_data,           32'd0);
        chk("mid_rst_sig_valid",  {31'b0, sig_valid},  32'd0);
        chk("mid_rst_cycles",     cycle_count,         32'd0);
        dmem_req = 1'b0; dmem_we = 1'b0;
        step();
        step();
        nrst_in = 1'b1;
        q_sig.delete();
        mdl_halted = 1'b0;
        repeat (3) step();
        chk("post_rst_cycles", cycle_count, 32'd3);
        dmem_op("r300_kept",  1'b0, 32'h0000_0C00, 4'h0, 32'h0, 4);

        // Halt: wrong value ignored, magic sets it, then writes have no effect
        dmem_op("w100_pre",   1'b1, 32'h0000_0100, 4'hF, 32'h0BADF00D, 4);
        dmem_op("halt_bad",   1'b1, C_HALT, 4'hF, 32'h12345678, 4);
        chk("halt_bad_flag", {31'b0, halted}, 32'd0);
        dmem_op("r_halt0",    1'b0, C_HALT, 4'h0, 32'h0, 4);
        dmem_op("halt_magic", 1'b1, C_HALT, 4'hF, C_MAGIC, 4);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        c_frozen = cycle_count;
        repeat (5) step();
        chk("cycles_frozen", cycle_count, c_frozen);
        dmem_op("w100_halted", 1'b1, 32'h0000_0100, 4'hF, 32'h99999999, 4);
        dmem_op("r100_kept",   1'b0, 32'h0000_0100, 4'h0, 32'h0, 4);
        dmem_op("r_halt1",     1'b0, C_HALT, 4'h0, 32'h0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
